sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator, directly upstream of edge_detector.
//  Accepts one raster-order pixel per valid cycle and buffers two image lines.
//  Emits complete 3x3 windows on win_p1..win_p9, which map 1:1 onto edge_detector pixel_in1..9.
//  Windows touching the image border are never emitted.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=3); line buffer depth
//  IMG_HEIGHT  480  lines per frame (>=3)
//  PIXEL_W     8    bits per pixel
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous reset, active-low
//  pix_in      in   PIXEL_W  input pixel, raster order
//  pix_valid   in   1        pix_in is accepted this cycle; no backpressure
//  pix_sof     in   1        qualified by pix_valid: this pixel is (row 0, col 0)
//  win_p1..9   out  PIXEL_W  window; p1-p3 top row (oldest line), p7-p9 bottom (newest); left->right
//  win_valid   out  1        1-cycle pulse: win_p1..9 hold a new complete window
//  frame_done  out  1        1-cycle pulse after pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted
// BEHAVIOUR
//  Reset (rst=0, async): col/row counters=0, window regs=0, win_p*=0, win_valid=0, frame_done=0.
//   Line-buffer RAM is not reset; stale contents are masked by the validity rule.
//  Accepted pixel at (r,c): shift window left one column.
//   New right column = {linebuf1[c], linebuf0[c], pix_in}, i.e. top, middle, bottom.
//   Then linebuf1[c]<=linebuf0[c] and linebuf0[c]<=pix_in (read-before-write, same cycle).
//  Validity: win_valid=1 in the cycle after an accepted pixel with r>=2 && c>=2.
//   The window is then centred on (r-1,c-1). Latency: 1 clock from pixel to window.
//  pix_valid=0: all state frozen, win_p* hold, win_valid=0. Gaps of any length are allowed.
//  Counters: c wraps IMG_WIDTH-1 -> 0 and increments r. r wraps IMG_HEIGHT-1 -> 0.
//   frame_done pulses the cycle after (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, same cycle as its window.
//  pix_sof with pix_valid: force (r,c)=(0,0) for this pixel, regardless of current counters.
//   A mid-frame sof aborts the frame: no frame_done, no window until new (2,2).
//  pix_sof without pix_valid: ignored.
//  Windows never span a line wrap. The first window of each line starts at c=2.
//   The shift register refills 2 columns per line.
//  Back-to-back frames: first window of frame N+1 contains only frame N+1 pixels.
//  Pixels are passed unmodified; no arithmetic on pixel data.
//  Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
// STRUCTURE
//  sobel_pkg: PIXEL_W default, IMG_WIDTH/IMG_HEIGHT defaults, window-index constants (P1..P9).
//   edge_detector shares these constants.
//  Sub-module sobel_line_buffer: 1W/1R RAM, depth IMG_WIDTH, PIXEL_W wide.
//   Combinational read, registered write; instantiated twice, in cascade.
//  Top level holds the counters, the 3x3 shift register, and the valid/frame_done logic.
// TESTING  (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*r+c)
//  1 Reset held, then released -> win_valid=0, frame_done=0, all win_p*=0x00.
//  2 Continuous 4x4 frame with sof on the first pixel -> exactly 4 win_valid pulses.
//    First: 00,01,02,10,11,12,20,21,22. Last: 11,12,13,21,22,23,31,32,33.
//    frame_done coincides with the last window.
//  3 Same frame with pix_valid toggling 1/0/0/1... -> identical window sequence; outputs hold in gaps.
//  4 sof asserted mid-frame at (1,2) -> no window before new (2,2); first window = 00..22 set as in 2.
//  5 rst driven low between clock edges mid-frame -> win_valid and win_p* are 0 immediately.
//    After release, frame restart reproduces test 2.
//  6 Two back-to-back frames, frame 2 = frame 1 + 0x80 -> frame 2 windows are all 0x80-offset.
//    No frame 1 values appear.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: default geometry and pixel width,
// plus the 3x3 window index map used by both this generator and edge_detector.
package sobel_pkg;

  localparam int unsigned PIXEL_W_DEF    = 8;
  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;

  localparam int unsigned WIN_SIZE = 9;

  // Window indices: P1..P3 top row (oldest line), P7..P9 bottom row (newest),
  // left to right within each row.
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned P3 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned P5 = 4;
  localparam int unsigned P6 = 5;
  localparam int unsigned P7 = 6;
  localparam int unsigned P8 = 7;
  localparam int unsigned P9 = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage: combinational read, registered write at the same
// address, so a read in the write cycle returns the previous line's pixel.
module sobel_line_buffer #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Write the new pixel into the line slot after it has been read out.
  // NOTE: the RAM has no reset; its stale contents never reach a valid window,
  // and leaving it unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two cascaded line buffers feed the right
// column of a 3x3 shift register; windows touching the border are suppressed.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned PIXEL_W    = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pix_in,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic [PIXEL_W-1:0] win_p1,
  output logic [PIXEL_W-1:0] win_p2,
  output logic [PIXEL_W-1:0] win_p3,
  output logic [PIXEL_W-1:0] win_p4,
  output logic [PIXEL_W-1:0] win_p5,
  output logic [PIXEL_W-1:0] win_p6,
  output logic [PIXEL_W-1:0] win_p7,
  output logic [PIXEL_W-1:0] win_p8,
  output logic [PIXEL_W-1:0] win_p9,
  output logic               win_valid,
  output logic               frame_done
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(2);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]      col_q, col_d, cur_col;
  logic [RW-1:0]      row_q, row_d, cur_row;
  logic [PIXEL_W-1:0] win_q [WIN_SIZE];
  logic [PIXEL_W-1:0] win_d [WIN_SIZE];
  logic               win_valid_q, win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [PIXEL_W-1:0] lb0_rd, lb1_rd;

  // A qualified start-of-frame overrides the running counters for this pixel.
  assign cur_col = (pix_valid && pix_sof) ? '0 : col_q;
  assign cur_row = (pix_valid && pix_sof) ? '0 : row_q;

  // Line 0 holds the previous row; line 1 holds the row before that.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIXEL_W)) u_lb0 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (cur_col),
    .wr_data (pix_in),
    .rd_data (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIXEL_W)) u_lb1 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (cur_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Next-state: shift the window, advance counters, flag valid windows and frame end.
  // NOTE: every signal gets its default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      win_d[P1] = win_q[P2];
      win_d[P2] = win_q[P3];
      win_d[P3] = lb1_rd;
      win_d[P4] = win_q[P5];
      win_d[P5] = win_q[P6];
      win_d[P6] = lb0_rd;
      win_d[P7] = win_q[P8];
      win_d[P8] = win_q[P9];
      win_d[P9] = pix_in;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
      end else begin
        col_d = cur_col + COL_ONE;
        row_d = cur_row;
      end
      win_valid_d  = (cur_row >= ROW_WIN0) && (cur_col >= COL_WIN0);
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  // State registers with asynchronous clear of counters, window and pulses.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_p1     = win_q[P1];
  assign win_p2     = win_q[P2];
  assign win_p3     = win_q[P3];
  assign win_p4     = win_q[P4];
  assign win_p5     = win_q[P5];
  assign win_p6     = win_q[P6];
  assign win_p7     = win_q[P7];
  assign win_p8     = win_q[P8];
  assign win_p9     = win_q[P9];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image, pixel value = base+16*r+c.
module tb_sobel_window_gen;

  typedef logic [8:0][7:0] win_t;  // element 0 is p1, element 8 is p9

  typedef struct {
    logic       valid;
    logic       sof;
    logic [7:0] pix;
    logic       exp_wv;
    logic       exp_fd;
    logic       chk_win;
    win_t       exp_win;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic [7:0] win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9;
  logic       win_valid;
  logic       frame_done;

  int   n_checks;
  int   n_errors;
  vec_t vq[$];
  win_t obs_q[$];
  logic last_was_win;
  win_t last_win;

  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .win_p1     (win_p1),
    .win_p2     (win_p2),
    .win_p3     (win_p3),
    .win_p4     (win_p4),
    .win_p5     (win_p5),
    .win_p6     (win_p6),
    .win_p7     (win_p7),
    .win_p8     (win_p8),
    .win_p9     (win_p9),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic win_t get_win();
    return {win_p9, win_p8, win_p7, win_p6, win_p5, win_p4, win_p3, win_p2, win_p1};
  endfunction

  // Expected window centred on (r,c) of a frame with the given base offset.
  function automatic win_t win_at(input logic [7:0] base, input int r, input int c);
    win_t w;
    for (int k = 0; k < 9; k++) begin
      w[k] = base + 8'(16 * (r - 1 + k / 3) + (c - 1 + k % 3));
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_pixel(input logic [7:0] base, input int r, input int c, input logic sof);
    vec_t v;
    v.valid   = 1'b1;
    v.sof     = sof;
    v.pix     = base + 8'(16 * r + c);
    v.exp_wv  = (r >= 2) && (c >= 2);
    v.exp_fd  = (r == 3) && (c == 3);
    v.chk_win = v.exp_wv;
    v.exp_win = v.exp_wv ? win_at(base, r - 1, c - 1) : '0;
    if (v.exp_wv) last_win = v.exp_win;
    last_was_win = v.exp_wv;
    vq.push_back(v);
  endtask

  // Idle cycle: window must hold if the last accepted pixel produced one.
  task automatic add_idle(input logic sof);
    vec_t v;
    v.valid   = 1'b0;
    v.sof     = sof;
    v.pix     = 8'hEE;
    v.exp_wv  = 1'b0;
    v.exp_fd  = 1'b0;
    v.chk_win = last_was_win;
    v.exp_win = last_win;
    vq.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] base, input int gaps);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        add_pixel(base, r, c, (r == 0) && (c == 0));
        for (int g = 0; g < gaps; g++) add_idle(g[0]);
      end
    end
  endtask

  // Apply the queued vectors, checking every cycle; then check the window count.
  task automatic run_vectors(input string name);
    int exp_n;
    exp_n = 0;
    obs_q.delete();
    for (int i = 0; i < vq.size(); i++) begin
      pix_valid = vq[i].valid;
      pix_sof   = vq[i].sof;
      pix_in    = vq[i].pix;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] win_valid", name, i), 72'(win_valid), 72'(vq[i].exp_wv));
      check($sformatf("%s[%0d] frame_done", name, i), 72'(frame_done), 72'(vq[i].exp_fd));
      if (vq[i].chk_win)
        check($sformatf("%s[%0d] window", name, i), get_win(), vq[i].exp_win);
      if (vq[i].exp_wv) exp_n++;
      if (win_valid) obs_q.push_back(get_win());
    end
    check($sformatf("%s window count", name), 72'(obs_q.size()), 72'(exp_n));
    vq.delete();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic check_obs(input string name, input int idx, input logic [71:0] exp);
    if (obs_q.size() > idx) begin
      check(name, obs_q[idx], exp);
    end else begin
      check({name, " missing"}, 72'(obs_q.size()), 72'(idx + 1));
    end
  endtask

  localparam logic [71:0] FIRST_W  = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] LAST_W   = 72'h33_32_31_23_22_21_13_12_11;
  localparam logic [71:0] FIRST_W2 = 72'hA2_A1_A0_92_91_90_82_81_80;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    last_was_win = 1'b0;
    last_win     = '0;
    rst          = 1'b0;
    pix_in       = 8'h00;
    pix_valid    = 1'b0;
    pix_sof      = 1'b0;

    // 1: reset state, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("reset win_valid", 72'(win_valid), 72'd0);
    check("reset window", get_win(), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset win_valid", 72'(win_valid), 72'd0);
    check("post-reset frame_done", 72'(frame_done), 72'd0);
    check("post-reset window", get_win(), 72'd0);

    // 2: continuous frame
    add_frame(8'h00, 0);
    run_vectors("t2");
    check("t2 count", 72'(obs_q.size()), 72'd4);
    check_obs("t2 first", 0, FIRST_W);
    check_obs("t2 last", 3, LAST_W);

    // 3: valid toggling 1/0/0, sof pulses in gaps must be ignored
    add_frame(8'h00, 2);
    run_vectors("t3");
    check_obs("t3 first", 0, FIRST_W);
    check_obs("t3 last", 3, LAST_W);

    // 4: sof at (1,2) aborts the partial frame
    last_was_win = 1'b0;
    for (int c = 0; c < 4; c++) add_pixel(8'h00, 0, c, c == 0);
    add_pixel(8'h00, 1, 0, 1'b0);
    add_pixel(8'h00, 1, 1, 1'b0);
    add_frame(8'h00, 0);
    run_vectors("t4");
    check("t4 count", 72'(obs_q.size()), 72'd4);
    check_obs("t4 first", 0, FIRST_W);

    // 5: asynchronous reset mid-frame, between clock edges
    last_was_win = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) add_pixel(8'h40, r, c, (r == 0) && (c == 0));
    for (int c = 0; c < 3; c++) add_pixel(8'h40, 2, c, 1'b0);
    run_vectors("t5pre");
    #2;
    rst = 1'b0;
    #1;
    check("t5 async win_valid", 72'(win_valid), 72'd0);
    check("t5 async window", get_win(), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    add_frame(8'h00, 0);
    run_vectors("t5");
    check_obs("t5 first", 0, FIRST_W);
    check_obs("t5 last", 3, LAST_W);

    // 6: back-to-back frames, second offset by 0x80
    add_frame(8'h00, 0);
    add_frame(8'h80, 0);
    run_vectors("t6");
    check("t6 count", 72'(obs_q.size()), 72'd8);
    check_obs("t6 frame2 first", 4, FIRST_W2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
